// File: rtl/alu_scheduler_if.sv
// ============================================================================
//  Module      : alu_scheduler_if
//  Description : Handshake and data bundle between two command requesters,
//                the alu_scheduler, a shared registered ALU and the response
//                consumer. Member names carry the direction as seen from the
//                scheduler (i_ = into the scheduler, o_ = out of it).
//  Modports    : slave  - scheduler side
//                master - environment side (requesters, ALU, response sink)
//  Parameters  : N opcode width, M operand width, K result width
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_scheduler_if #(
    parameter int N = 4,
    parameter int M = 8,
    parameter int K = 8
);
    // requester 0
    logic         i_req0_valid;
    logic         o_req0_ready;
    logic [N-1:0] i_req0_op;
    logic [M-1:0] i_req0_a;
    logic [M-1:0] i_req0_b;
    // requester 1
    logic         i_req1_valid;
    logic         o_req1_ready;
    logic [N-1:0] i_req1_op;
    logic [M-1:0] i_req1_a;
    logic [M-1:0] i_req1_b;
    // shared ALU
    logic [N-1:0] o_alu_op;
    logic [M-1:0] o_alu_a;
    logic [M-1:0] o_alu_b;
    logic [K-1:0] i_alu_result;
    logic [3:0]   i_alu_status;
    // response
    logic         o_rsp_valid;
    logic         o_rsp_id;
    logic [K-1:0] o_rsp_result;
    logic [3:0]   o_rsp_status;
    logic         i_rsp_ready;

    modport slave (
        input  i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
        input  i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
        input  i_alu_result, i_alu_status, i_rsp_ready,
        output o_req0_ready, o_req1_ready,
        output o_alu_op, o_alu_a, o_alu_b,
        output o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status
    );

    modport master (
        output i_req0_valid, i_req0_op, i_req0_a, i_req0_b,
        output i_req1_valid, i_req1_op, i_req1_a, i_req1_b,
        output i_alu_result, i_alu_status, i_rsp_ready,
        input  o_req0_ready, o_req1_ready,
        input  o_alu_op, o_alu_a, o_alu_b,
        input  o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_status
    );
endinterface

`default_nettype wire

// File: rtl/alu_scheduler.sv
// ============================================================================
//  Module      : alu_scheduler
//  Description : Round-robin arbiter between two requesters sharing one
//                registered (1-cycle latency) ALU. One command in flight:
//                IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  Ports       : i_clk   - clock, rising edge
//                i_reset - synchronous, active-low reset
//                bus     - alu_scheduler_if.slave (requests, ALU, response)
//  Parameters  : N opcode width, M operand width, K result width
//  Macros      : ALU_SCHED_OPCHECK_EN - when defined, commands with
//                op[N-1]=1 bypass the ALU and answer result 0 / status 4'hF
//                straight from IDLE to RESP.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_scheduler #(
    parameter int N = 4,
    parameter int M = 8,
    parameter int K = 8
) (
    input  wire logic           i_clk,
    input  wire logic           i_reset,
    alu_scheduler_if.slave      bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t       r_state;
    logic         r_last;        // id of the last granted requester
    logic [N-1:0] r_alu_op;
    logic [M-1:0] r_alu_a;
    logic [M-1:0] r_alu_b;
    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [K-1:0] r_rsp_result;
    logic [3:0]   r_rsp_status;

    logic         w_idle_ok;
    logic         w_gnt0;
    logic         w_gnt1;
    logic         w_accept;
    logic [N-1:0] w_acc_op;
    logic [M-1:0] w_acc_a;
    logic [M-1:0] w_acc_b;

    // Readiness is offered only in IDLE and never while reset is held.
    // On a tie the requester that was not granted last wins.
    assign w_idle_ok = (r_state == S_IDLE) && i_reset;
    assign w_gnt0    = bus.i_req0_valid && (!bus.i_req1_valid ||  r_last);
    assign w_gnt1    = bus.i_req1_valid && (!bus.i_req0_valid || !r_last);
    assign w_accept  = w_idle_ok && (w_gnt0 || w_gnt1);

    assign w_acc_op  = w_gnt1 ? bus.i_req1_op : bus.i_req0_op;
    assign w_acc_a   = w_gnt1 ? bus.i_req1_a  : bus.i_req0_a;
    assign w_acc_b   = w_gnt1 ? bus.i_req1_b  : bus.i_req0_b;

    assign bus.o_req0_ready = w_idle_ok && w_gnt0;
    assign bus.o_req1_ready = w_idle_ok && w_gnt1;

    assign bus.o_alu_op     = r_alu_op;
    assign bus.o_alu_a      = r_alu_a;
    assign bus.o_alu_b      = r_alu_b;
    assign bus.o_rsp_valid  = r_rsp_valid;
    assign bus.o_rsp_id     = r_rsp_id;
    assign bus.o_rsp_result = r_rsp_result;
    assign bus.o_rsp_status = r_rsp_status;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= S_IDLE;
            r_last       <= 1'b1;    // makes req0 win the first tie
            r_alu_op     <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_status <= 4'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_last   <= w_gnt1;
                        r_rsp_id <= w_gnt1;
`ifdef ALU_SCHED_OPCHECK_EN
                        if (w_acc_op[N-1]) begin
                            // Unimplemented group: answer locally, ALU
                            // inputs keep the previous command.
                            r_rsp_result <= '0;
                            r_rsp_status <= 4'hF;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            r_alu_op <= w_acc_op;
                            r_alu_a  <= w_acc_a;
                            r_alu_b  <= w_acc_b;
                            r_state  <= S_ISSUE;
                        end
`else
                        r_alu_op <= w_acc_op;
                        r_alu_a  <= w_acc_a;
                        r_alu_b  <= w_acc_b;
                        r_state  <= S_ISSUE;
`endif
                    end
                end
                S_ISSUE: begin
                    // ALU samples the operands on this edge
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_rsp_result <= bus.i_alu_result;
                    r_rsp_status <= bus.i_alu_status;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_scheduler.sv
// ============================================================================
//  Module      : tb_alu_scheduler
//  Description : Self-checking bench for alu_scheduler. A registered ALU
//                model drives the ALU result port; a cycle-level behavioural
//                model (command age counter, round-robin pointer) predicts
//                every output each cycle. Directed scenarios add literal
//                expectations, then a randomized phase runs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_scheduler;

    localparam int N = 4;
    localparam int M = 8;
    localparam int K = 8;

`ifdef ALU_SCHED_OPCHECK_EN
    localparam bit OPCHECK = 1'b1;
`else
    localparam bit OPCHECK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    alu_scheduler_if #(.N(N), .M(M), .K(K)) bus ();

    alu_scheduler #(.N(N), .M(M), .K(K)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU function: {status, result}; status = {zero, carry, msb, parity}
    function automatic logic [11:0] alu_fn(input logic [3:0] op,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] w;
        case (op[2:0])
            3'd0: w = {1'b0, a};
            3'd1: w = {1'b0, a} + {1'b0, b};
            3'd2: w = {1'b0, a} - {1'b0, b};
            3'd3: w = {1'b0, a & b};
            3'd4: w = {1'b0, a | b};
            3'd5: w = {1'b0, a ^ b};
            3'd6: w = {a, 1'b0};
            default: w = {1'b0, ~a};
        endcase
        return {(w[7:0] == 8'd0), w[8], w[7], ^w[7:0], w[7:0]};
    endfunction

    // Shared ALU: registered, one cycle latency
    always @(posedge clk) begin
        {bus.i_alu_status, bus.i_alu_result} <= alu_fn(bus.o_alu_op, bus.o_alu_a, bus.o_alu_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_known = 1'b0;
    bit         m_after_rst = 1'b0;
    int         m_age = -1;      // cycles since accept; -1 = nothing in flight
    int         m_lat = 3;       // age at which the response appears
    bit         m_last = 1'b1;
    logic [3:0] m_alu_op = '0;
    logic [7:0] m_alu_a = '0, m_alu_b = '0;
    logic       m_id = 1'b0;
    logic [7:0] m_res = '0;
    logic [3:0] m_st = '0;

    always @(negedge clk) begin
        bit         e_r0, e_r1, e_rv, bad;
        logic [3:0] op;
        logic [7:0] a, b;
        logic [11:0] f;
        e_r0 = (m_age < 0) && rst_n && bus.i_req0_valid && (!bus.i_req1_valid || m_last);
        e_r1 = (m_age < 0) && rst_n && bus.i_req1_valid && (!bus.i_req0_valid || !m_last);
        e_rv = (m_age >= m_lat);
        if (m_known) begin
            chk("ready0", bus.o_req0_ready, e_r0);
            chk("ready1", bus.o_req1_ready, e_r1);
            chk("rsp_valid", bus.o_rsp_valid, e_rv);
            chk("alu_op", bus.o_alu_op, m_alu_op);
            chk("alu_a", bus.o_alu_a, m_alu_a);
            chk("alu_b", bus.o_alu_b, m_alu_b);
            if (e_rv || m_after_rst) begin
                chk("rsp_id", bus.o_rsp_id, m_id);
                chk("rsp_result", bus.o_rsp_result, m_res);
                chk("rsp_status", bus.o_rsp_status, m_st);
            end
        end
        // advance to what the next rising edge must produce
        if (!rst_n) begin
            m_known = 1'b1; m_after_rst = 1'b1; m_age = -1; m_last = 1'b1;
            m_alu_op = '0; m_alu_a = '0; m_alu_b = '0;
            m_id = 1'b0; m_res = '0; m_st = '0;
        end else begin
            m_after_rst = 1'b0;
            if (m_age < 0) begin
                if ((e_r0 && bus.i_req0_valid) || (e_r1 && bus.i_req1_valid)) begin
                    m_id   = e_r1;
                    m_last = e_r1;
                    op = e_r1 ? bus.i_req1_op : bus.i_req0_op;
                    a  = e_r1 ? bus.i_req1_a  : bus.i_req0_a;
                    b  = e_r1 ? bus.i_req1_b  : bus.i_req0_b;
                    bad = OPCHECK && op[3];
                    if (bad) begin
                        m_res = '0; m_st = 4'hF; m_lat = 1;
                    end else begin
                        f = alu_fn(op, a, b);
                        m_res = f[7:0]; m_st = f[11:8]; m_lat = 3;
                        m_alu_op = op; m_alu_a = a; m_alu_b = b;
                    end
                    m_age = 1;
                end
            end else if (m_age >= m_lat) begin
                if (bus.i_rsp_ready) m_age = -1;
            end else begin
                m_age++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at a negedge: reports the id accepted in the current or a later
    // cycle, then moves to the following negedge.
    task automatic wait_accept(output int id);
        id = -1;
        for (int i = 0; i < 30; i++) begin
            if (bus.o_req0_ready && bus.i_req0_valid) begin id = 0; break; end
            if (bus.o_req1_ready && bus.i_req1_valid) begin id = 1; break; end
            @(negedge clk);
        end
        if (id < 0) chk("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int id;
        int n;
        errs = 0; checks = 0;
        rst_n = 1'b0;
        bus.i_req0_valid = 1'b0; bus.i_req0_op = '0; bus.i_req0_a = '0; bus.i_req0_b = '0;
        bus.i_req1_valid = 1'b0; bus.i_req1_op = '0; bus.i_req1_a = '0; bus.i_req1_b = '0;
        bus.i_rsp_ready  = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_rsp_valid", bus.o_rsp_valid, 1'b0);
        chk("rst_alu_op", bus.o_alu_op, 4'd0);
        step(); rst_n = 1'b1;

        // single command, no backpressure
        bus.i_req0_valid = 1'b1; bus.i_req0_op = 4'b0001; bus.i_req0_a = 8'd3; bus.i_req0_b = 8'd4;
        @(negedge clk);  chk("t1_ready0", bus.o_req0_ready, 1'b1);
        step(); bus.i_req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_issue_op", bus.o_alu_op, 4'd1);
        chk("t1_issue_a", bus.o_alu_a, 8'd3);
        chk("t1_issue_b", bus.o_alu_b, 8'd4);
        @(negedge clk);  chk("t1_early_valid", bus.o_rsp_valid, 1'b0);
        @(negedge clk);
        chk("t1_valid", bus.o_rsp_valid, 1'b1);
        chk("t1_id", bus.o_rsp_id, 1'b0);
        chk("t1_result", bus.o_rsp_result, 8'd7);
        chk("t1_status", bus.o_rsp_status, 4'b0001);

        // backpressure
        step();
        bus.i_rsp_ready = 1'b0;
        bus.i_req1_valid = 1'b1; bus.i_req1_op = 4'd3; bus.i_req1_a = 8'hF0; bus.i_req1_b = 8'h3C;
        @(negedge clk);  chk("t2_ready1", bus.o_req1_ready, 1'b1);
        step();
        bus.i_req1_valid = 1'b0;
        bus.i_req0_valid = 1'b1; bus.i_req0_op = 4'd2; bus.i_req0_a = 8'd5; bus.i_req0_b = 8'd9;
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", bus.o_rsp_valid, 1'b1);
            chk("t2_hold_id", bus.o_rsp_id, 1'b1);
            chk("t2_hold_result", bus.o_rsp_result, 8'h30);
            chk("t2_hold_status", bus.o_rsp_status, 4'b0000);
            chk("t2_hold_ready0", bus.o_req0_ready, 1'b0);
        end
        step(); bus.i_rsp_ready = 1'b1;
        @(negedge clk);  chk("t2_resp_exit_ready0", bus.o_req0_ready, 1'b0);
        @(negedge clk);  chk("t2_resume_ready0", bus.o_req0_ready, 1'b1);
        step(); bus.i_req0_valid = 1'b0;
        repeat (5) step();

        // reset while in WAIT
        bus.i_req0_valid = 1'b1; bus.i_req0_op = 4'd5; bus.i_req0_a = 8'd1; bus.i_req0_b = 8'd2;
        @(negedge clk);  chk("t3_ready0", bus.o_req0_ready, 1'b1);
        step(); bus.i_req0_valid = 1'b0;
        step(); rst_n = 1'b0;
        bus.i_req0_valid = 1'b1; bus.i_req0_op = 4'd6; bus.i_req0_a = 8'h81; bus.i_req0_b = 8'h00;
        bus.i_req1_valid = 1'b1; bus.i_req1_op = 4'd7; bus.i_req1_a = 8'h55; bus.i_req1_b = 8'h00;
        @(negedge clk);
        chk("t3_rst_ready0", bus.o_req0_ready, 1'b0);
        chk("t3_rst_ready1", bus.o_req1_ready, 1'b0);
        step(); rst_n = 1'b1;
        @(negedge clk);
        chk("t3_zero_valid", bus.o_rsp_valid, 1'b0);
        chk("t3_zero_result", bus.o_rsp_result, 8'd0);
        chk("t3_zero_alu_op", bus.o_alu_op, 4'd0);
        chk("t3_zero_alu_a", bus.o_alu_a, 8'd0);
        chk("t3_tie_ready1", bus.o_req1_ready, 1'b0);
        for (int k = 0; k < 4; k++) begin
            wait_accept(id);
            chk("t4_grant_seq", id, k % 2);
        end
        step(); bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
        repeat (6) step();

        // opcode from the unimplemented group
        bus.i_req0_valid = 1'b1; bus.i_req0_op = 4'b1010; bus.i_req0_a = 8'd20; bus.i_req0_b = 8'd6;
        @(negedge clk);  chk("t5_ready0", bus.o_req0_ready, 1'b1);
        step(); bus.i_req0_valid = 1'b0;
        n = 1;
        @(negedge clk);
        while (!bus.o_rsp_valid && n < 10) begin n++; @(negedge clk); end
`ifdef ALU_SCHED_OPCHECK_EN
        chk("t5_latency", n, 1);
        chk("t5_result", bus.o_rsp_result, 8'd0);
        chk("t5_status", bus.o_rsp_status, 4'hF);
        chk("t5_alu_op_kept", bus.o_alu_op, 4'd7);
        chk("t5_alu_a_kept", bus.o_alu_a, 8'h55);
`else
        chk("t5_latency", n, 3);
        chk("t5_result", bus.o_rsp_result, 8'h0E);
        chk("t5_status", bus.o_rsp_status, 4'b0001);
        chk("t5_alu_op", bus.o_alu_op, 4'b1010);
        chk("t5_alu_a", bus.o_alu_a, 8'd20);
`endif
        step();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            rst_n            = ($urandom_range(0, 79) != 0);
            bus.i_rsp_ready  = ($urandom_range(0, 3) != 0);
            bus.i_req0_valid = ($urandom_range(0, 9) < 6);
            bus.i_req1_valid = ($urandom_range(0, 9) < 6);
            bus.i_req0_op = 4'($urandom); bus.i_req0_a = 8'($urandom); bus.i_req0_b = 8'($urandom);
            bus.i_req1_op = 4'($urandom); bus.i_req1_a = 8'($urandom); bus.i_req1_b = 8'($urandom);
            step();
        end
        rst_n = 1'b1; bus.i_rsp_ready = 1'b1;
        bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
        repeat (8) step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

`default_nettype wire
